// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/flush controller: the controller
// state encoding and the architectural zero register index.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Controller states; encodings are fixed so debug probes can decode them.
    typedef enum logic [1:0] {
        PIPE_ST_RUN      = 2'd0,
        PIPE_ST_REDIRECT = 2'd1,
        PIPE_ST_MEM_WAIT = 2'd2
    } pipe_state_e;

    // x0 is hardwired to zero, so a write to it can never create a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in
// decode reads a register that the load currently in execute will write.
// Kept separate so a future forwarding unit can reuse the same comparator.
//
// Ports:
//   rs1_i, rs2_i         D-stage source register indices
//   rs1_used_i, rs2_used_i  D-stage instruction actually reads rs1 / rs2
//   mem_ren_i            E-stage instruction is a load
//   wb_rd_i              E-stage destination register
//   load_use_o           decode must wait one cycle for the load data
// -----------------------------------------------------------------------------
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic       mem_ren_i,
    input  logic [4:0] wb_rd_i,
    output logic       load_use_o
);

    logic rs1Hit;
    logic rs2Hit;

    // A match only counts when the operand is really read, and never for x0.
    always_comb begin
        rs1Hit     = rs1_used_i && (rs1_i == wb_rd_i);
        rs2Hit     = rs2_used_i && (rs2_i == wb_rd_i);
        load_use_o = mem_ren_i && (wb_rd_i != REG_ZERO) && (rs1Hit || rs2Hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central hazard and flush controller for the 5-stage F/D/E/M/W pipeline.
// Produces the stall/flush strobes for the pipeline registers, owns the fetch
// redirect after an execute-stage mispredict (held across dmem wait states),
// and runs a sticky watchdog for a data memory that never becomes ready.
//
// Optional build macro: PIPE_CTRL_PERF_EN adds three 32-bit event counters
// (load-use stalls, mispredicts, memory-wait cycles).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   decode_i_*                   D-stage source register usage
//   regE_i_mem_ren, regE_i_wb_rd E-stage load and destination
//   exe_i_mispredict/_target     E-stage branch resolution
//   regM_i_mem_req, dmem_i_ready M-stage memory handshake
//   ctrl_o_*                     stall/flush strobes, redirect, watchdog
//   ctrl_o_perf_*                event counters (PIPE_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      decode_i_rs1,
    input  logic [4:0]      decode_i_rs2,
    input  logic            decode_i_rs1_used,
    input  logic            decode_i_rs2_used,
    input  logic            regE_i_mem_ren,
    input  logic [4:0]      regE_i_wb_rd,
    input  logic            exe_i_mispredict,
    input  logic [XLEN-1:0] exe_i_target,
    input  logic            regM_i_mem_req,
    input  logic            dmem_i_ready,
    output logic            ctrl_o_pc_stall,
    output logic            ctrl_o_regD_stall,
    output logic            ctrl_o_regD_flush,
    output logic            ctrl_o_regE_stall,
    output logic            ctrl_o_regE_flush,
    output logic            ctrl_o_regM_stall,
    output logic            ctrl_o_regW_flush,
    output logic            ctrl_o_redirect_valid,
    output logic [XLEN-1:0] ctrl_o_redirect_pc,
    output logic            ctrl_o_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     ctrl_o_perf_loaduse,
    output logic [31:0]     ctrl_o_perf_mispred,
    output logic [31:0]     ctrl_o_perf_memwait
`endif
);

    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] CNT_MAX     = {TO_W{1'b1}};

    pipe_state_e     state_q, state_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            redir_pend_q, redir_pend_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    logic memStall;
    logic loadUse;
    logic loadUseAcc;
    logic mispredAcc;

    pipe_hazard_detect u_hazard (
        .rs1_i      (decode_i_rs1),
        .rs2_i      (decode_i_rs2),
        .rs1_used_i (decode_i_rs1_used),
        .rs2_used_i (decode_i_rs2_used),
        .mem_ren_i  (regE_i_mem_ren),
        .wb_rd_i    (regE_i_wb_rd),
        .load_use_o (loadUse)
    );

    assign memStall = regM_i_mem_req && !dmem_i_ready;

    // State and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PIPE_ST_RUN;
            redir_pc_q   <= '0;
            redir_pend_q <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state and strobe generation. A memory stall freezes everything up
    // to M and bubbles W; otherwise a pending redirect beats a fresh mispredict,
    // which beats a load-use hazard. The cycle that leaves MEM_WAIT behaves
    // like RUN, and a redirect parked during the wait issues one cycle later.
    always_comb begin
        state_d      = state_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;

        ctrl_o_pc_stall       = 1'b0;
        ctrl_o_regD_stall     = 1'b0;
        ctrl_o_regD_flush     = 1'b0;
        ctrl_o_regE_stall     = 1'b0;
        ctrl_o_regE_flush     = 1'b0;
        ctrl_o_regM_stall     = 1'b0;
        ctrl_o_regW_flush     = 1'b0;
        ctrl_o_redirect_valid = 1'b0;
        loadUseAcc            = 1'b0;
        mispredAcc            = 1'b0;

        if (memStall) begin
            ctrl_o_pc_stall   = 1'b1;
            ctrl_o_regD_stall = 1'b1;
            ctrl_o_regE_stall = 1'b1;
            ctrl_o_regM_stall = 1'b1;
            ctrl_o_regW_flush = 1'b1;
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + 1'b1;
            if (wait_cnt_d >= TIMEOUT_CNT) begin
                timeout_d = 1'b1;
            end
            state_d = PIPE_ST_MEM_WAIT;
            case (state_q)
                PIPE_ST_RUN:      redir_pend_d = 1'b0;
                PIPE_ST_REDIRECT: redir_pend_d = 1'b1;
                default:          redir_pend_d = redir_pend_q;
            endcase
        end else begin
            wait_cnt_d = '0;
            if (state_q == PIPE_ST_REDIRECT) begin
                ctrl_o_redirect_valid = 1'b1;
                ctrl_o_regD_flush     = 1'b1;
                state_d               = PIPE_ST_RUN;
            end else begin
                redir_pend_d = 1'b0;
                if ((state_q == PIPE_ST_MEM_WAIT) && redir_pend_q) begin
                    state_d = PIPE_ST_REDIRECT;
                end else begin
                    state_d = PIPE_ST_RUN;
                end
                if (exe_i_mispredict) begin
                    ctrl_o_regD_flush = 1'b1;
                    ctrl_o_regE_flush = 1'b1;
                    mispredAcc        = 1'b1;
                    // An already-parked target is older and must not be lost.
                    if (state_d != PIPE_ST_REDIRECT) begin
                        redir_pc_d = exe_i_target;
                    end
                    state_d = PIPE_ST_REDIRECT;
                end else if (loadUse) begin
                    ctrl_o_pc_stall   = 1'b1;
                    ctrl_o_regD_stall = 1'b1;
                    ctrl_o_regE_flush = 1'b1;
                    loadUseAcc        = 1'b1;
                end
            end
        end

        // Reset drains the pipe with bubbles and never stalls.
        if (rst) begin
            ctrl_o_pc_stall       = 1'b0;
            ctrl_o_regD_stall     = 1'b0;
            ctrl_o_regE_stall     = 1'b0;
            ctrl_o_regM_stall     = 1'b0;
            ctrl_o_regD_flush     = 1'b1;
            ctrl_o_regE_flush     = 1'b1;
            ctrl_o_regW_flush     = 1'b1;
            ctrl_o_redirect_valid = 1'b0;
        end
    end

    assign ctrl_o_redirect_pc = ctrl_o_redirect_valid ? redir_pc_q : '0;
    assign ctrl_o_mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfLoadUse_q;
    logic [31:0] perfMispred_q;
    logic [31:0] perfMemWait_q;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfLoadUse_q <= '0;
            perfMispred_q <= '0;
            perfMemWait_q <= '0;
        end else begin
            if (loadUseAcc) perfLoadUse_q <= perfLoadUse_q + 32'd1;
            if (mispredAcc) perfMispred_q <= perfMispred_q + 32'd1;
            if (memStall)   perfMemWait_q <= perfMemWait_q + 32'd1;
        end
    end

    assign ctrl_o_perf_loaduse = perfLoadUse_q;
    assign ctrl_o_perf_mispred = perfMispred_q;
    assign ctrl_o_perf_memwait = perfMemWait_q;
`else
    logic unusedAcc;
    assign unusedAcc = loadUseAcc ^ mispredAcc;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Scenario bench for pipe_ctrl (MEM_TIMEOUT=4, TO_W=3). Each scenario queues
// its per-cycle stimulus with the expected strobes; expectations go onto a
// scoreboard as each cycle is driven and are popped when outputs are sampled.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    // Expected strobe word: {pc_stall, D_stall, D_flush, E_stall, E_flush,
    //                        M_stall, W_flush, redirect_valid, mem_timeout}
    localparam logic [8:0] IDLE  = 9'b000000000;
    localparam logic [8:0] LU    = 9'b110010000;
    localparam logic [8:0] MISP  = 9'b001010000;
    localparam logic [8:0] REDIR = 9'b001000010;
    localparam logic [8:0] STALL = 9'b110101100;
    localparam logic [8:0] RSTV  = 9'b001010100;
    localparam logic [8:0] TO    = 9'b000000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, wbRd;
    logic        rs1Used, rs2Used, memRen, mispredict, memReq, dmemReady;
    logic [63:0] target;

    logic        pcStall, dStall, dFlush, eStall, eFlush, mStall, wFlush;
    logic        redirValid, memTimeout;
    logic [63:0] redirPc;
    logic [8:0]  obsCtl;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfLoadUse, perfMispred, perfMemWait;
`endif

    typedef struct {
        string       name;
        logic        rst, mreq, rdy, mis, ren, u1, u2;
        logic [63:0] tgt;
        logic [4:0]  wb, rs1, rs2;
        logic [8:0]  ctl;
        logic [63:0] pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [63:0] pc;
    } exp_t;

    vec_t planQ[$];
    exp_t sbQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(64), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .decode_i_rs1          (rs1),
        .decode_i_rs2          (rs2),
        .decode_i_rs1_used     (rs1Used),
        .decode_i_rs2_used     (rs2Used),
        .regE_i_mem_ren        (memRen),
        .regE_i_wb_rd          (wbRd),
        .exe_i_mispredict      (mispredict),
        .exe_i_target          (target),
        .regM_i_mem_req        (memReq),
        .dmem_i_ready          (dmemReady),
        .ctrl_o_pc_stall       (pcStall),
        .ctrl_o_regD_stall     (dStall),
        .ctrl_o_regD_flush     (dFlush),
        .ctrl_o_regE_stall     (eStall),
        .ctrl_o_regE_flush     (eFlush),
        .ctrl_o_regM_stall     (mStall),
        .ctrl_o_regW_flush     (wFlush),
        .ctrl_o_redirect_valid (redirValid),
        .ctrl_o_redirect_pc    (redirPc),
        .ctrl_o_mem_timeout    (memTimeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .ctrl_o_perf_loaduse   (perfLoadUse),
        .ctrl_o_perf_mispred   (perfMispred),
        .ctrl_o_perf_memwait   (perfMemWait)
`endif
    );

    assign obsCtl = {pcStall, dStall, dFlush, eStall, eFlush, mStall, wFlush,
                     redirValid, memTimeout};

    // Queue one cycle of stimulus with the strobes it must produce.
    function automatic void add(string n, logic r, logic mreq, logic rdy,
                                logic mis, logic [63:0] tgt, logic ren,
                                logic [4:0] wb, logic [4:0] s1, logic u1,
                                logic [4:0] s2, logic u2,
                                logic [8:0] ctl, logic [63:0] pc);
        vec_t v;
        v.name = n;  v.rst = r;   v.mreq = mreq; v.rdy = rdy; v.mis = mis;
        v.tgt  = tgt; v.ren = ren; v.wb  = wb;   v.rs1 = s1;  v.u1 = u1;
        v.rs2  = s2; v.u2 = u2;   v.ctl = ctl;  v.pc  = pc;
        planQ.push_back(v);
    endfunction

    function automatic void addIdle(string n, logic [8:0] ctl, logic [63:0] pc);
        add(n, 0, 0, 1, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ctl, pc);
    endfunction

    task automatic driveVec(input vec_t v);
        rst = v.rst; memReq = v.mreq; dmemReady = v.rdy; mispredict = v.mis;
        target = v.tgt; memRen = v.ren; wbRd = v.wb; rs1 = v.rs1;
        rs1Used = v.u1; rs2 = v.rs2; rs2Used = v.u2;
    endtask

    task automatic pushExp(input vec_t v);
        exp_t e;
        e.name = v.name; e.ctl = v.ctl; e.pc = v.pc;
        sbQ.push_back(e);
    endtask

    task automatic test_reset();
        vec_t v; exp_t e;
        add("rst_stall_mis", 1, 1, 0, 1, 64'h1000, 1, 5'd3, 5'd3, 1, 5'd0, 0, RSTV, 64'h0);
        add("rst_hold",      1, 0, 1, 0, 64'h0,    0, 5'd0, 5'd0, 0, 5'd0, 0, RSTV, 64'h0);
        addIdle("rst_release", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t v; exp_t e;
        add("lu_rs2_hit",    0, 0, 1, 0, 64'h0, 1, 5'd5, 5'd0, 0, 5'd5, 1, LU,   64'h0);
        add("lu_after",      0, 0, 1, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd5, 1, IDLE, 64'h0);
        add("lu_x0",         0, 0, 1, 0, 64'h0, 1, 5'd0, 5'd0, 1, 5'd0, 1, IDLE, 64'h0);
        add("lu_unused",     0, 0, 1, 0, 64'h0, 1, 5'd5, 5'd5, 0, 5'd7, 1, IDLE, 64'h0);
        add("lu_rs1_hit",    0, 0, 1, 0, 64'h0, 1, 5'd9, 5'd9, 1, 5'd2, 0, LU,   64'h0);
        add("lu_not_load",   0, 0, 1, 0, 64'h0, 0, 5'd9, 5'd9, 1, 5'd9, 1, IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_mispredict();
        vec_t v; exp_t e;
        add("mp_flush",      0, 0, 1, 1, 64'h8000_0040, 0, 5'd0, 5'd0, 0, 5'd0, 0, MISP,  64'h0);
        add("mp_redirect",   0, 0, 1, 1, 64'h1111_2222, 1, 5'd4, 5'd4, 1, 5'd0, 0, REDIR, 64'h8000_0040);
        addIdle("mp_done", IDLE, 64'h0);
        add("mp_and_lu",     0, 0, 1, 1, 64'h1234,      1, 5'd6, 5'd6, 1, 5'd6, 1, MISP,  64'h0);
        addIdle("mp_lu_redirect", REDIR, 64'h1234);
        addIdle("mp_lu_done", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_mem_stall_run();
        vec_t v; exp_t e;
        add("ms_masks_mp",   0, 1, 0, 1, 64'hA000, 1, 5'd8, 5'd8, 1, 5'd0, 0, STALL, 64'h0);
        add("ms_exit_mp",    0, 1, 1, 1, 64'hA000, 0, 5'd0, 5'd0, 0, 5'd0, 0, MISP,  64'h0);
        addIdle("ms_redirect", REDIR, 64'hA000);
        addIdle("ms_done", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_redirect_memwait();
        vec_t v; exp_t e;
        add("rw_mp",         0, 0, 1, 1, 64'hDEAD_BEEF_0000_1000, 0, 5'd0, 5'd0, 0, 5'd0, 0, MISP,  64'h0);
        add("rw_stall1",     0, 1, 0, 0, 64'h0,    0, 5'd0, 5'd0, 0, 5'd0, 0, STALL, 64'h0);
        add("rw_stall2",     0, 1, 0, 1, 64'h5555, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL, 64'h0);
        add("rw_stall3",     0, 1, 0, 0, 64'h0,    1, 5'd2, 5'd2, 1, 5'd0, 0, STALL, 64'h0);
        add("rw_ready",      0, 1, 1, 0, 64'h0,    0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  64'h0);
        addIdle("rw_redirect", REDIR, 64'hDEAD_BEEF_0000_1000);
        addIdle("rw_done", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t v; exp_t e;
        // Flag is registered: it appears on the cycle after the 4th stall.
        for (int i = 1; i <= 9; i++) begin
            add($sformatf("to_wait%0d", i), 0, 1, 0, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0,
                (i <= 4) ? STALL : (STALL | TO), 64'h0);
        end
        add("to_ready",      0, 1, 1, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE | TO, 64'h0);
        addIdle("to_sticky", IDLE | TO, 64'h0);
        add("to_rst",        1, 0, 1, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, RSTV | TO, 64'h0);
        addIdle("to_cleared", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

    task automatic test_reset_midwait();
        vec_t v; exp_t e;
        add("rm_mp",         0, 0, 1, 1, 64'h40, 0, 5'd0, 5'd0, 0, 5'd0, 0, MISP,  64'h0);
        add("rm_stall1",     0, 1, 0, 0, 64'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, STALL, 64'h0);
        add("rm_stall2",     0, 1, 0, 0, 64'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, STALL, 64'h0);
        add("rm_rst",        1, 1, 0, 0, 64'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, RSTV,  64'h0);
        addIdle("rm_no_redir1", IDLE, 64'h0);
        addIdle("rm_no_redir2", IDLE, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        vec_t v; exp_t e;
        add("pf_rst",        1, 0, 1, 0, 64'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, RSTV, 64'h0);
        add("pf_lu",         0, 0, 1, 0, 64'h0,  1, 5'd3, 5'd3, 1, 5'd0, 0, LU,   64'h0);
        add("pf_mp",         0, 0, 1, 1, 64'h80, 0, 5'd0, 5'd0, 0, 5'd0, 0, MISP, 64'h0);
        addIdle("pf_redirect", REDIR, 64'h80);
        for (int i = 1; i <= 5; i++) begin
            add($sformatf("pf_wait%0d", i), 0, 1, 0, 0, 64'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0,
                (i <= 4) ? STALL : (STALL | TO), 64'h0);
        end
        addIdle("pf_idle", IDLE | TO, 64'h0);
        while (planQ.size() > 0) begin
            v = planQ.pop_front();
            @(negedge clk); driveVec(v); pushExp(v); #1;
            e = sbQ.pop_front(); vectors++;
            if ({obsCtl, redirPc} !== {e.ctl, e.pc}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h", e.name, obsCtl, redirPc, e.ctl, e.pc);
            end
        end
        vectors++;
        if ({perfLoadUse, perfMispred, perfMemWait} !== {32'd1, 32'd1, 32'd5}) begin
            miscompares++;
            $display("[TB] FAIL perf_counters: got lu=%0d mp=%0d mw=%0d, want lu=1 mp=1 mw=5",
                     perfLoadUse, perfMispred, perfMemWait);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; wbRd = '0; rs1Used = 1'b0; rs2Used = 1'b0;
        memRen = 1'b0; mispredict = 1'b0; memReq = 1'b0; dmemReady = 1'b1; target = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_stall_run();
        test_redirect_memwait();
        test_timeout();
        test_reset_midwait();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
